// File: rtl/body_rate_controller_pkg.sv
// Shared widths, gain defaults, state encoding and saturation helpers for the rate PID stage.
package body_rate_controller_pkg;
    localparam int RW                = 16;
    localparam int FIXED_POINT_SHIFT = 4;

    localparam logic signed [RW-1:0] KP_MULT_D     = 16'sd1;
    localparam int                   KP_SHIFT_D    = 0;
    localparam logic signed [RW-1:0] KI_MULT_D     = 16'sd1;
    localparam int                   KI_SHIFT_D    = 3;
    localparam logic signed [RW-1:0] KD_MULT_D     = 16'sd1;
    localparam int                   KD_SHIFT_D    = 1;
    localparam logic signed [RW-1:0] INTEG_LIMIT_D = 16'sd1600;
    localparam logic signed [RW-1:0] OUT_LIMIT_D   = 16'sd1600;
    localparam logic signed [RW-1:0] ARM_MIN_D     = 16'sd2 <<< FIXED_POINT_SHIFT;

    localparam logic [1:0] AX_YAW = 2'd2;

    typedef enum logic [2:0] {
        S_WAIT, S_LATCH, S_ERR, S_PTERM, S_ITERM, S_DTERM, S_SUMLIM, S_DONE
    } state_t;

    function automatic logic signed [33:0] sx34(input logic signed [RW-1:0] v);
        return {{18{v[RW-1]}}, v};
    endfunction

    function automatic logic signed [RW-1:0] clamp16(input logic signed [33:0] v,
                                                     input logic signed [RW-1:0] lim);
        logic signed [33:0] hi;
        hi = sx34(lim);
        if (v > hi)       return lim;
        else if (v < -hi) return -lim;
        else              return v[RW-1:0];
    endfunction

    function automatic logic signed [RW-1:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767)       return 16'sh7fff;
        else if (v < -34'sd32768) return 16'sh8000;
        else                      return v[RW-1:0];
    endfunction
endpackage

// File: rtl/rate_scale_sat.sv
// Combinational (a*k)>>>s with 16-bit saturation; one instance shared by P, I and D.
module rate_scale_sat
    import body_rate_controller_pkg::*;
(
    input  logic signed [RW+1:0] i_a,
    input  logic signed [RW-1:0] i_k,
    input  logic        [3:0]    i_s,
    output logic signed [RW-1:0] o_y
);
    logic signed [33:0] w_a, w_k, w_prod;

    assign w_a    = {{16{i_a[RW+1]}}, i_a};
    assign w_k    = sx34(i_k);
    assign w_prod = w_a * w_k;
    assign o_y    = sat16(w_prod >>> i_s);
endmodule

// File: rtl/body_rate_controller.sv
// Rate PID stage: time-shares one scale/saturate unit across roll, pitch, yaw P/I/D terms.
module body_rate_controller
    import body_rate_controller_pkg::*;
#(
    parameter logic signed [15:0] KP_MULT     = KP_MULT_D,
    parameter int                 KP_SHIFT    = KP_SHIFT_D,
    parameter logic signed [15:0] KI_MULT     = KI_MULT_D,
    parameter int                 KI_SHIFT    = KI_SHIFT_D,
    parameter logic signed [15:0] KD_MULT     = KD_MULT_D,
    parameter int                 KD_SHIFT    = KD_SHIFT_D,
    parameter logic signed [15:0] INTEG_LIMIT = INTEG_LIMIT_D,
    parameter logic signed [15:0] OUT_LIMIT   = OUT_LIMIT_D,
    parameter logic signed [15:0] ARM_MIN     = ARM_MIN_D
) (
    input  logic               us_clk,
    input  logic               resetn,
    input  logic               start_signal,
    input  logic               integ_clear,
    input  logic signed [15:0] throttle_rate_in,
    input  logic signed [15:0] yaw_rate_target,
    input  logic signed [15:0] pitch_rate_target,
    input  logic signed [15:0] roll_rate_target,
    input  logic signed [15:0] yaw_rate_actual,
    input  logic signed [15:0] pitch_rate_actual,
    input  logic signed [15:0] roll_rate_actual,
    output logic signed [15:0] throttle_out,
    output logic signed [15:0] yaw_cmd,
    output logic signed [15:0] pitch_cmd,
    output logic signed [15:0] roll_cmd,
    output logic               active_signal,
    output logic               complete_signal
);
    state_t r_state, w_state_nx;
    logic        [1:0]  r_axis;
    logic signed [15:0] r_thr, r_err, r_p, r_d;
    logic signed [15:0] r_tgt [3];
    logic signed [15:0] r_act [3];
    logic signed [15:0] r_integ [3];
    logic signed [15:0] r_prev [3];
    logic signed [15:0] r_pend [2];

    logic signed [17:0] w_a;
    logic signed [15:0] w_k, w_y, w_err, w_cmd;
    logic        [3:0]  w_s;
    logic               w_disarm;

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) r_state <= S_WAIT;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_WAIT:   if (start_signal) w_state_nx = S_LATCH;
            S_LATCH:  w_state_nx = S_ERR;
            S_ERR:    w_state_nx = S_PTERM;
            S_PTERM:  w_state_nx = S_ITERM;
            S_ITERM:  w_state_nx = S_DTERM;
            S_DTERM:  w_state_nx = S_SUMLIM;
            S_SUMLIM: w_state_nx = (r_axis == AX_YAW) ? S_DONE : S_ERR;
            S_DONE:   w_state_nx = S_WAIT;
            default:  w_state_nx = S_WAIT;
        endcase
    end

    assign complete_signal = (r_state == S_DONE);
    assign active_signal   = (r_state != S_WAIT) && (r_state != S_DONE);
    assign w_disarm        = (r_thr < ARM_MIN);
    assign w_err           = sat16(sx34(r_tgt[r_axis]) - sx34(r_act[r_axis]));
    assign w_cmd           = clamp16(sx34(r_p) + sx34(r_integ[r_axis]) + sx34(r_d), OUT_LIMIT);

    always_comb begin
        w_a = {{2{r_err[15]}}, r_err};
        w_k = KP_MULT;
        w_s = 4'(KP_SHIFT);
        case (r_state)
            S_ITERM: begin
                w_k = KI_MULT;
                w_s = 4'(KI_SHIFT);
            end
            S_DTERM: begin
                w_a = {{2{r_err[15]}}, r_err} - {{2{r_prev[r_axis][15]}}, r_prev[r_axis]};
                w_k = KD_MULT;
                w_s = 4'(KD_SHIFT);
            end
            default: ;
        endcase
    end

    rate_scale_sat u_scale (.i_a(w_a), .i_k(w_k), .i_s(w_s), .o_y(w_y));

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_axis       <= '0;
            r_thr        <= '0;
            r_err        <= '0;
            r_p          <= '0;
            r_d          <= '0;
            throttle_out <= '0;
            yaw_cmd      <= '0;
            pitch_cmd    <= '0;
            roll_cmd     <= '0;
            for (int i = 0; i < 3; i++) begin
                r_tgt[i]   <= '0;
                r_act[i]   <= '0;
                r_integ[i] <= '0;
                r_prev[i]  <= '0;
            end
            for (int i = 0; i < 2; i++) r_pend[i] <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (integ_clear) begin
                        for (int i = 0; i < 3; i++) begin
                            r_integ[i] <= '0;
                            r_prev[i]  <= '0;
                        end
                    end
                    if (start_signal) begin
                        r_thr    <= throttle_rate_in;
                        r_tgt[0] <= roll_rate_target;
                        r_tgt[1] <= pitch_rate_target;
                        r_tgt[2] <= yaw_rate_target;
                        r_act[0] <= roll_rate_actual;
                        r_act[1] <= pitch_rate_actual;
                        r_act[2] <= yaw_rate_actual;
                    end
                end
                S_LATCH: begin
                    r_axis <= '0;
                    if (w_disarm)
                        for (int i = 0; i < 3; i++) r_integ[i] <= '0;
                end
                S_ERR:   r_err <= w_err;
                S_PTERM: r_p   <= w_y;
                // Disarmed runs keep the integrator pinned at zero instead of accumulating.
                S_ITERM: r_integ[r_axis] <= w_disarm ? 16'sd0
                                            : clamp16(sx34(r_integ[r_axis]) + sx34(w_y), INTEG_LIMIT);
                S_DTERM: begin
                    r_d             <= w_y;
                    r_prev[r_axis]  <= r_err;
                end
                S_SUMLIM: begin
                    r_axis <= r_axis + 2'd1;
                    if (r_axis == AX_YAW) begin
                        roll_cmd     <= r_pend[0];
                        pitch_cmd    <= r_pend[1];
                        yaw_cmd      <= w_cmd;
                        throttle_out <= r_thr;
                    end else begin
                        r_pend[r_axis[0]] <= w_cmd;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
